// File: rtl/netclk_pkg.sv
// Shared constants and types for the Econet network clock generator and its
// companion clock detector.
package netclk_pkg;

    localparam int NETCLK_W           = 12;
    localparam int NETCLK_DEF_PERIOD  = 160;
    localparam int NETCLK_DEF_MARK    = 32;
    // Detector timeout; the generator holdoff must be longer than this so the
    // detector always declares loss of clock before a takeover is attempted.
    localparam int NETCLK_DET_TIMEOUT = 2048;
    localparam int NETCLK_HOLDOFF     = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLDOFF,
        ST_RUN,
        ST_STOP
    } netclk_state_t;

endpackage

// File: rtl/netclk_gen_phase.sv
// Phase counter and mark comparator with double-buffered period/mark so a new
// configuration only takes effect on a period boundary.
module netclk_gen_phase
    import netclk_pkg::*;
#(
    parameter int W          = NETCLK_W,
    parameter int DEF_PERIOD = NETCLK_DEF_PERIOD,
    parameter int DEF_MARK   = NETCLK_DEF_MARK
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         run,
    input  logic         halt,
    input  logic         cfg_wr,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_mark,
    output logic         wrap,
    output logic         level
);

    logic [W-1:0] phase_reg;
    logic [W-1:0] period_reg;
    logic [W-1:0] mark_reg;
    logic [W-1:0] pend_period_reg;
    logic [W-1:0] pend_mark_reg;
    logic         pend_valid_reg;
    logic         level_reg;
    logic [W-1:0] phase_inc;
    logic         apply;

    assign phase_inc = phase_reg + W'(1);
    assign wrap      = run && (phase_reg == period_reg - W'(1));
    assign apply     = (start || wrap) && pend_valid_reg;
    assign level     = level_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg       <= '0;
            period_reg      <= W'(DEF_PERIOD);
            mark_reg        <= W'(DEF_MARK);
            pend_period_reg <= W'(DEF_PERIOD);
            pend_mark_reg   <= W'(DEF_MARK);
            pend_valid_reg  <= 1'b0;
            level_reg       <= 1'b0;
        end else begin
            if (start)
                phase_reg <= '0;
            else if (run)
                phase_reg <= wrap ? '0 : phase_inc;

            if (apply) begin
                period_reg <= pend_period_reg;
                mark_reg   <= pend_mark_reg;
            end

            // A load on the apply edge is kept pending for the next boundary.
            if (cfg_wr) begin
                pend_period_reg <= cfg_period;
                pend_mark_reg   <= cfg_mark;
                pend_valid_reg  <= 1'b1;
            end else if (apply) begin
                pend_valid_reg  <= 1'b0;
            end

            // Phase 0 is always high because every accepted mark is at least 1.
            if (start)
                level_reg <= 1'b1;
            else if (halt)
                level_reg <= 1'b0;
            else if (run)
                level_reg <= wrap ? 1'b1 : (phase_inc < mark_reg);
        end
    end

endmodule

// File: rtl/netclk_gen.sv
// Econet network clock generator: takes over the shared netclk line after a
// holdoff when no other station clocks it, and always finishes a period on release.
module netclk_gen
    import netclk_pkg::*;
#(
    parameter int W              = NETCLK_W,
    parameter int DEF_PERIOD     = NETCLK_DEF_PERIOD,
    parameter int DEF_MARK       = NETCLK_DEF_MARK,
    parameter int HOLDOFF_CYCLES = NETCLK_HOLDOFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         no_clock,
    input  logic         auto_en,
    input  logic         force_on,
    input  logic         cfg_load,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_mark,
    output logic         netclk_out,
    output logic         netclk_oe,
    output logic         active,
    output logic         cfg_err
);

    localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);

    if (HOLDOFF_CYCLES <= NETCLK_DET_TIMEOUT) begin : g_bad_holdoff
        $error("netclk_gen: HOLDOFF_CYCLES must exceed the detector timeout");
    end

    netclk_state_t state_reg;
    netclk_state_t state_next;
    logic [HO_W-1:0] hold_cnt_reg;
    logic            oe_reg;
    logic            cfg_err_reg;
    logic            cfg_valid;
    logic            wrap;
    logic            start;
    logic            run;
    logic            halt;
    logic            drive_next;

    // mark >= 1 and mark < period together imply period >= 2.
    assign cfg_valid = (cfg_mark != '0) && (cfg_mark < cfg_period) && (cfg_period >= W'(2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (force_on)
                    state_next = ST_RUN;
                else if (auto_en && no_clock)
                    state_next = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (!no_clock || !auto_en)
                    state_next = ST_IDLE;
                else if (force_on || (hold_cnt_reg == HO_W'(HOLDOFF_CYCLES - 1)))
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!force_on && !auto_en)
                    state_next = ST_STOP;
            end
            ST_STOP: begin
                if (force_on || auto_en)
                    state_next = ST_RUN;
                else if (wrap)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        run        = (state_reg == ST_RUN) || (state_reg == ST_STOP);
        start      = !run && (state_next == ST_RUN);
        halt       = (state_reg == ST_STOP) && (state_next == ST_IDLE);
        drive_next = (state_next == ST_RUN) || (state_next == ST_STOP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_reg <= '0;
            oe_reg       <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= (state_reg == ST_HOLDOFF) ? hold_cnt_reg + HO_W'(1) : '0;
            oe_reg       <= drive_next;
            if (cfg_load)
                cfg_err_reg <= !cfg_valid;
        end
    end

    netclk_gen_phase #(
        .W          (W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_MARK   (DEF_MARK)
    ) u_phase (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .run        (run),
        .halt       (halt),
        .cfg_wr     (cfg_load && cfg_valid),
        .cfg_period (cfg_period),
        .cfg_mark   (cfg_mark),
        .wrap       (wrap),
        .level      (netclk_out)
    );

    assign netclk_oe = oe_reg;
    assign active    = oe_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: doc/netclk_gen.md
Name: netclk_gen

Overview:
- Econet network clock generator. It sits directly upstream of the network clock detector and drives the shared netclk line when no other station supplies a clock.
- Auto mode: it watches the detector's no_clock flag, waits a holdoff, then drives a programmable-period, programmable-mark clock with an output enable.
- Force mode drives the clock unconditionally.
- On shutdown it always completes the current period, so no runt pulses reach the line.

Parameters:
- W, 12, width of the period/mark/phase counters.
- DEF_PERIOD, 160, reset period in clk cycles.
- DEF_MARK, 32, reset high time in clk cycles.
- HOLDOFF_CYCLES, 4096, number of consecutive no_clock cycles required before driving. Must exceed the detector timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- no_clock  in  1  from the clock detector; high means no external clock is present
- auto_en  in  1  enables automatic takeover
- force_on  in  1  drives the clock regardless of no_clock
- cfg_load  in  1  single-cycle strobe that captures cfg_period/cfg_mark
- cfg_period  in  W  requested period in clk cycles
- cfg_mark  in  W  requested high time in clk cycles
- netclk_out  out  1  generated clock level
- netclk_oe  out  1  line driver enable
- active  out  1  high while in state RUN or STOP
- cfg_err  out  1  sticky flag for an invalid configuration

Behaviour:
- Reset (async, any time, including mid-period):
  - netclk_out=0, netclk_oe=0, active=0, cfg_err=0.
  - State=IDLE, phase=0, period=DEF_PERIOD, mark=DEF_MARK, pending_valid=0.
- All outputs are registered.
- Config validity rule: 1 <= cfg_mark < cfg_period, with cfg_period >= 2.
  - Valid cfg_load: store into the pending registers, set pending_valid=1, clear cfg_err.
  - Invalid cfg_load: set cfg_err=1; pending and active values are unchanged.
  - cfg_err stays set until the next valid load.
- Pending application:
  - Pending values become active only on a RUN-entry edge or a period-wrap edge, after which pending_valid clears.
  - A cfg_load on the same edge as a wrap is not applied at that wrap; it becomes pending for the next one.
- State IDLE:
  - force_on=1: go to RUN on this edge.
  - Otherwise, auto_en=1 and no_clock=1: go to HOLDOFF, holdoff count=0.
- State HOLDOFF:
  - If no_clock=0 or auto_en=0: return to IDLE.
  - force_on=1: go to RUN immediately.
  - When the count reaches HOLDOFF_CYCLES-1 with no_clock still high: go to RUN.
- RUN entry edge: phase<=0, netclk_out<=1, netclk_oe<=1, active<=1.
- State RUN:
  - Each edge: phase increments; at period-1 it wraps to 0.
  - netclk_out <= (next_phase < mark).
  - no_clock is ignored in RUN, since the detector now sees the locally driven clock.
  - If force_on=0 and auto_en=0: go to STOP.
- State STOP:
  - Keeps counting and driving.
  - On the wrap edge (phase==period-1): netclk_out<=0, netclk_oe<=0, active<=0, go to IDLE.
  - If force_on or auto_en reasserts during STOP: return to RUN with no phase disturbance.
- Arithmetic: phase is W bits, unsigned, and is never compared against a value that is not yet latched.
- Latency:
  - force_on sampled high in IDLE: oe and netclk_out are both high after that edge.
  - Auto path: the first drive edge is HOLDOFF_CYCLES+1 edges after no_clock is first sampled high.

Decomposition:
- Shared package netclk_pkg:
  - State enum (IDLE, HOLDOFF, RUN, STOP).
  - Constant NETCLK_W.
  - Default period/mark constants, shared with the clock detector's timeout constant so HOLDOFF_CYCLES can be checked against it.
- One sub-module, netclk_gen_phase:
  - Holds the phase counter, mark comparator, and the active/pending period/mark registers.
  - Outputs: wrap strobe and level.
- The top level holds the FSM, holdoff counter and config validation.

Test Plan:
- Reset release, force_on=1 with defaults -> oe=1 on the next edge; netclk_out high for 32 cycles and low for 128, repeating with period 160.
- auto_en=1, no_clock held high -> oe rises exactly 4097 edges after no_clock is first sampled. A variant that drops no_clock at count 4000 returns to IDLE with oe never asserted.
- While in RUN, cfg_load period=10 mark=3 mid-period -> the current 160-cycle period completes, then 3 high / 7 low. A cfg_load with mark=10 period=10 -> cfg_err=1 and timing is unchanged.
- Drop force_on at phase 50 -> the clock continues to phase 159; oe, active and netclk_out are 0 after the wrap edge. Reasserting force_on at phase 100 keeps RUN with no glitch.
- Assert reset at phase 10 (netclk_out high) -> outputs drop immediately (async). After release, state is IDLE and defaults are restored.
- cfg_load coincident with the wrap edge -> the old pending value is applied at that wrap and the new value at the following wrap.
